// File: rtl/freq_meter.sv
// freq_meter: counts rising edges of a slow asynchronous square wave over a
// fixed gate window of GATE_CYCLES clk cycles. At the end of each window it
// publishes a held result with a one-cycle valid strobe.
//
// Ports:
//   clk         reference clock
//   rst         asynchronous, active-high reset
//   en          level; 1 = run back-to-back gate windows, 0 = idle
//   sig_in      asynchronous signal under measurement
//   meas_count  rising edges counted in the last completed window
//   meas_valid  one-cycle pulse when meas_count updates
//   meas_ovf    last completed window saturated the counter
//   no_signal   last completed window counted zero edges
//   busy        1 while in GATE
//
// State | meaning
// IDLE  | counters held at zero, waiting for en
// GATE  | gate window running; edges accumulate until the terminal cycle
module freq_meter #(
    parameter int FREQ        = 50_000_000,
    parameter int GATE_CYCLES = FREQ,
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] meas_count,
    output logic             meas_valid,
    output logic             meas_ovf,
    output logic             no_signal,
    output logic             busy
);

    localparam int GW = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GW-1:0]    GATE_TERM = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        GATE = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   sig_rise;

    logic [GW-1:0]    gate_cnt_q, gate_cnt_d;
    logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
    logic             sat_q, sat_d;

    logic             terminal;
    logic             at_max;
    logic             publish;
    logic [CNT_W-1:0] result;
    logic             result_ovf;

    // Input synchronizer followed by the previous-value register for edge detect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sig_rise = sync_q[SYNC_STAGES-1] & ~prev_q;

    assign terminal = (state_q == GATE) && (gate_cnt_q == GATE_TERM);
    assign at_max   = (edge_cnt_q == CNT_MAX);

    // The edge arriving on the terminal cycle still belongs to the ending window.
    assign result     = at_max ? CNT_MAX : (edge_cnt_q + {{(CNT_W-1){1'b0}}, sig_rise});
    assign result_ovf = sat_q | (at_max & sig_rise);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            sat_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            gate_cnt_q <= gate_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            sat_q      <= sat_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        gate_cnt_d = gate_cnt_q;
        edge_cnt_d = edge_cnt_q;
        sat_d      = sat_q;
        publish    = 1'b0;

        case (state_q)
            IDLE: begin
                gate_cnt_d = '0;
                edge_cnt_d = '0;
                sat_d      = 1'b0;
                if (en) begin
                    state_d = GATE;
                end
            end

            GATE: begin
                if (terminal) begin
                    // Counters clear so a following window starts with no gap cycle.
                    publish    = 1'b1;
                    gate_cnt_d = '0;
                    edge_cnt_d = '0;
                    sat_d      = 1'b0;
                    state_d    = en ? GATE : IDLE;
                end else if (!en) begin
                    gate_cnt_d = '0;
                    edge_cnt_d = '0;
                    sat_d      = 1'b0;
                    state_d    = IDLE;
                end else begin
                    gate_cnt_d = gate_cnt_q + GW'(1);
                    if (sig_rise) begin
                        if (at_max) begin
                            sat_d = 1'b1;
                        end else begin
                            edge_cnt_d = edge_cnt_q + CNT_W'(1);
                        end
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meas_count <= '0;
            meas_valid <= 1'b0;
            meas_ovf   <= 1'b0;
            no_signal  <= 1'b0;
        end else begin
            meas_valid <= publish;
            if (publish) begin
                meas_count <= result;
                meas_ovf   <= result_ovf;
                no_signal  <= (result == '0);
            end
        end
    end

    assign busy = (state_q == GATE);

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter. Two instances share all inputs: a 32-bit
// counter instance and a 3-bit counter instance used for the saturation case.
// Both use a 100-cycle gate window.
module tb_freq_meter;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        sig_in;
    logic        gen_val = 1'b0;
    logic        man_val = 1'b0;
    int          sig_period = 0;
    int          ph = 0;

    logic [31:0] meas_count;
    logic        meas_valid, meas_ovf, no_signal, busy;
    logic [2:0]  meas_count3;
    logic        meas_valid3, meas_ovf3, no_signal3, busy3;

    int n_checks = 0;
    int n_pass   = 0;

    assign sig_in = (sig_period != 0) ? gen_val : man_val;

    always #5 clk = ~clk;

    // Periodic source: high for period/2 cycles, low for the rest.
    always @(negedge clk) begin
        if (sig_period != 0) begin
            gen_val <= (ph < sig_period / 2);
            ph      <= (ph >= sig_period - 1) ? 0 : ph + 1;
        end
    end

    freq_meter #(.FREQ(100), .GATE_CYCLES(100), .CNT_W(32), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .en(en), .sig_in(sig_in),
        .meas_count(meas_count), .meas_valid(meas_valid), .meas_ovf(meas_ovf),
        .no_signal(no_signal), .busy(busy)
    );

    freq_meter #(.FREQ(100), .GATE_CYCLES(100), .CNT_W(3), .SYNC_STAGES(2)) dut3 (
        .clk(clk), .rst(rst), .en(en), .sig_in(sig_in),
        .meas_count(meas_count3), .meas_valid(meas_valid3), .meas_ovf(meas_ovf3),
        .no_signal(no_signal3), .busy(busy3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Ticks until meas_valid is seen or the budget runs out; n = ticks taken.
    task automatic wait_valid(input int budget, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!meas_valid && n < budget);
    endtask

    function automatic logic sched(input int w, input int i);
        case (w)
            0:       return (i >= 10 && i < 15) || (i >= 97);
            1:       return (i < 20) || (i >= 50 && i < 55) || (i >= 98);
            default: return (i < 10) || (i >= 40 && i < 45);
        endcase
    endfunction

    initial begin
        int n;
        int seen;
        int total;
        int bexp [3];
        bexp = '{2, 1, 2};

        rst = 1'b1;
        en  = 1'b0;
        repeat (3) tick();
        check("rst_count", meas_count, 0);
        check("rst_valid", 32'(meas_valid), 0);
        check("rst_ovf", 32'(meas_ovf), 0);
        check("rst_nosig", 32'(no_signal), 0);
        check("rst_busy", 32'(busy), 0);

        rst = 1'b0;
        seen = 0;
        repeat (50) begin
            tick();
            if (busy || meas_valid) seen++;
        end
        check("idle_quiet", seen, 0);

        // Steady 10-cycle period.
        en = 1'b1;
        sig_period = 10;
        wait_valid(200, n);
        check("first_latency", n, 101);
        check("first_range", 32'(meas_count >= 9 && meas_count <= 11), 1);
        tick();
        check("valid_one_cycle", 32'(meas_valid), 0);
        wait_valid(200, n);
        check("steady_interval", n, 99);
        check("steady_count", meas_count, 10);
        check("steady_ovf", 32'(meas_ovf), 0);
        check("steady_nosig", 32'(no_signal), 0);
        check("steady_busy", 32'(busy), 1);
        wait_valid(200, n);
        check("steady_interval2", n, 100);
        check("steady_count2", meas_count, 10);

        // No signal.
        sig_period = 0;
        man_val = 1'b0;
        wait_valid(200, n);
        wait_valid(200, n);
        check("nosig_count", meas_count, 0);
        check("nosig_flag", 32'(no_signal), 1);
        wait_valid(200, n);
        check("nosig_interval", n, 100);
        check("nosig_count2", meas_count, 0);

        // Window boundary: an edge landing on the terminal cycle, then one a cycle late.
        total = 0;
        for (int w = 0; w < 3; w++) begin
            for (int i = 0; i < 100; i++) begin
                man_val = sched(w, i);
                tick();
            end
            check($sformatf("bnd_valid%0d", w), 32'(meas_valid), 1);
            check($sformatf("bnd_count%0d", w), meas_count, bexp[w]);
            total += int'(meas_count);
        end
        check("bnd_total", total, 5);

        // Abort at gate_cnt = 50.
        repeat (50) tick();
        check("abort_busy_before", 32'(busy), 1);
        en = 1'b0;
        tick();
        check("abort_busy_after", 32'(busy), 0);
        check("abort_no_valid", 32'(meas_valid), 0);
        sig_period = 10;
        seen = 0;
        repeat (150) begin
            tick();
            if (meas_valid || busy) seen++;
        end
        check("abort_quiet", seen, 0);
        check("abort_held", meas_count, 2);

        en = 1'b1;
        wait_valid(200, n);
        check("rerun_latency", n, 101);
        check("rerun_count", meas_count, 10);
        check("rerun_ovf", 32'(meas_ovf), 0);

        // Saturation on the 3-bit instance.
        sig_period = 4;
        wait_valid(200, n);
        wait_valid(200, n);
        check("ovf_count3", 32'(meas_count3), 7);
        check("ovf_flag3", 32'(meas_ovf3), 1);
        check("ovf_valid3", 32'(meas_valid3), 1);
        check("p4_count", meas_count, 25);
        check("p4_ovf", 32'(meas_ovf), 0);

        sig_period = 20;
        wait_valid(200, n);
        wait_valid(200, n);
        check("p20_count3", 32'(meas_count3), 5);
        check("p20_ovf3", 32'(meas_ovf3), 0);
        check("p20_count", meas_count, 5);
        check("p20_nosig", 32'(no_signal), 0);

        // Asynchronous reset mid-run.
        rst = 1'b1;
        #1;
        check("arst_count", meas_count, 0);
        check("arst_valid", 32'(meas_valid), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_count3", 32'(meas_count3), 0);
        check("arst_nosig3", 32'(no_signal3), 0);
        check("arst_busy3", 32'(busy3), 0);
        tick();
        rst = 1'b0;
        en = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
